// File: rtl/div23_pkg.sv
// Shared constants, types and the single remainder-step function for the
// constant divide-by-23 sequencer.
package div23_pkg;

    localparam int DIVISOR = 23;
    localparam int REM_W   = 5;

    typedef logic [REM_W-1:0] rem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    // Returns {q_bit, rem_next}; t = 2*r + b never exceeds 45 for legal r.
    function automatic logic [REM_W:0] rem_step(input rem_t rem_in, input logic bit_in);
        logic [REM_W:0] t;
        t = {rem_in, bit_in};
        if (t >= (REM_W+1)'(DIVISOR)) begin
            rem_step = {1'b1, REM_W'(t - (REM_W+1)'(DIVISOR))};
        end else begin
            rem_step = {1'b0, t[REM_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/div23_rem_step.sv
// One combinational restoring step of the divide-by-23 remainder recurrence:
// a 6-input / 6-output table mapping {rem_in, bit_in} to {q_bit, rem_out}.
module div23_rem_step (
    input  logic [4:0] rem_in,
    input  logic       bit_in,
    output logic [4:0] rem_out,
    output logic       q_bit
);
    import div23_pkg::*;

    logic [REM_W:0] w_step;

    assign w_step  = rem_step(rem_in, bit_in);
    assign q_bit   = w_step[REM_W];
    assign rem_out = w_step[REM_W-1:0];

endmodule

// File: rtl/div23_seq_ctrl.sv
// Sequencing controller for divide-by-23: accepts a dividend, walks it MSB
// first BITS_PER_CYCLE bits per clock, and holds quotient/remainder until taken.
//
// state | meaning
// IDLE  | ready for a new dividend
// RUN   | stepping through dividend bits, counter counts down to 1
// DONE  | result valid and held until out_ready
module div23_seq_ctrl #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int DIVISOR        = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [4:0]       out_remainder,
    output logic             busy
);
    import div23_pkg::*;

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    if (DIVISOR != div23_pkg::DIVISOR) begin : g_bad_divisor
        $error("div23_seq_ctrl supports only DIVISOR = 23");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("div23_seq_ctrl BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_width
        $error("div23_seq_ctrl WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    ctrl_state_e r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shift_step;
    rem_t             r_rem, w_rem_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_alive;

    logic [BITS_PER_CYCLE:0][REM_W-1:0] w_chain;
    logic [BITS_PER_CYCLE-1:0]          w_qbits;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after STEPS cycles the shift register holds the full quotient.
    assign w_chain[0] = r_rem;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div23_rem_step u_step (
            .rem_in  (w_chain[k]),
            .bit_in  (r_shift[WIDTH-1-k]),
            .rem_out (w_chain[k+1]),
            .q_bit   (w_qbits[BITS_PER_CYCLE-1-k])
        );
    end

    if (WIDTH > BITS_PER_CYCLE) begin : g_shift_wide
        assign w_shift_step = {r_shift[WIDTH-BITS_PER_CYCLE-1:0], w_qbits};
    end else begin : g_shift_narrow
        assign w_shift_step = w_qbits;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_shift_nxt = in_dividend;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = CNT_W'(STEPS);
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_shift_nxt = w_shift_step;
                w_rem_nxt   = w_chain[BITS_PER_CYCLE];
                w_cnt_nxt   = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_alive <= 1'b1;
        end
    end

    // r_alive keeps in_ready low until the first clock after reset release.
    assign in_ready      = r_alive && (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign busy          = (r_state == RUN);
    assign out_quotient  = out_valid ? r_shift : '0;
    assign out_remainder = out_valid ? r_rem : '0;

    a_rem_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_rem < REM_W'(DIVISOR));

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_quotient) && $stable(out_remainder)));

endmodule
